// File: rtl/csr_access_unit.sv
// ---------------------------------------------------------------------------
// csr_access_unit
//
// Issue-side front end of the CSR file. One CSR instruction (CSRRW / CSRRS /
// CSRRC) is accepted per request. The source operand is either the
// zero-extended immediate or the rs1 value of the lowest active lane. The
// unit then performs a single-cycle read-modify-write on the CSR data block.
// It returns the old CSR value, replicated on every lane, for writeback.
// Accesses to the FP CSRs (fflags/frm/fcsr) are held back while the FPU
// still has operations in flight for the requesting warp.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_*                 dispatch request (valid/ready handshake)
//   fpu_pending           per-warp "FPU ops in flight" flags
//   csr_read_*            read port to the CSR data block; csr_read_data
//                         is the combinational read result
//   csr_write_*           write port to the CSR data block
//   csr_busy              unit busy, feeds the CSR file's busy input
//   rsp_*                 writeback response (valid/ready handshake)
// ---------------------------------------------------------------------------
module csr_access_unit #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 4,
    parameter int UUID_BITS   = 44,
    parameter int NR_BITS     = 5,
    localparam int NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [UUID_BITS-1:0]      req_uuid,
    input  logic [NW_BITS-1:0]        req_wid,
    input  logic [NUM_THREADS-1:0]    req_tmask,
    input  logic [1:0]                req_op,
    input  logic                      req_use_imm,
    input  logic [4:0]                req_imm,
    input  logic [11:0]               req_addr,
    input  logic [NUM_THREADS*32-1:0] req_rs1_data,
    input  logic [NR_BITS-1:0]        req_rd,
    input  logic                      req_wb,

    input  logic [NUM_WARPS-1:0]      fpu_pending,

    output logic                      csr_read_enable,
    output logic [UUID_BITS-1:0]      csr_read_uuid,
    output logic [11:0]               csr_read_addr,
    output logic [NW_BITS-1:0]        csr_read_wid,
    input  logic [31:0]               csr_read_data,

    output logic                      csr_write_enable,
    output logic [UUID_BITS-1:0]      csr_write_uuid,
    output logic [11:0]               csr_write_addr,
    output logic [NW_BITS-1:0]        csr_write_wid,
    output logic [31:0]               csr_write_data,

    output logic                      csr_busy,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [UUID_BITS-1:0]      rsp_uuid,
    output logic [NW_BITS-1:0]        rsp_wid,
    output logic [NUM_THREADS-1:0]    rsp_tmask,
    output logic [NUM_THREADS*32-1:0] rsp_data,
    output logic [NR_BITS-1:0]        rsp_rd,
    output logic                      rsp_wb
);

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RSP  = 2'b10
    } state_t;

    state_t state;
    state_t state_next;

    // rs1 value of the lowest-numbered active lane. Scanning from the top
    // down lets the lowest set bit overwrite any higher one.
    function automatic logic [31:0] first_lane_data(
        input logic [NUM_THREADS-1:0]    tmask,
        input logic [NUM_THREADS*32-1:0] rs1
    );
        logic [31:0] data;
        data = 32'd0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (tmask[i]) begin
                data = rs1[i*32 +: 32];
            end
        end
        return data;
    endfunction

    // New CSR value for the read-modify-write. The illegal op 00 never
    // writes; returning the old value keeps the data port benign.
    function automatic logic [31:0] rmw_data(
        input logic [1:0]  op,
        input logic [31:0] old_val,
        input logic [31:0] src
    );
        logic [31:0] data;
        case (op)
            OP_RW:   data = src;
            OP_RS:   data = old_val | src;
            OP_RC:   data = old_val & ~src;
            default: data = old_val;
        endcase
        return data;
    endfunction

    // Latched request fields (data only, no reset needed)
    logic [UUID_BITS-1:0]      uuid_p0;
    logic [NW_BITS-1:0]        wid_p0;
    logic [NUM_THREADS-1:0]    tmask_p0;
    logic [1:0]                op_p0;
    logic [11:0]               addr_p0;
    logic [NR_BITS-1:0]        rd_p0;
    logic                      wb_p0;
    logic [31:0]               src_p0;
    logic                      wr_req_p0;

    // Captured old CSR value, replicated per lane
    logic [NUM_THREADS*32-1:0] rsp_data_p1;

    logic req_fire;
    logic access;
    logic fp_csr;
    logic fp_stall;

    assign req_fire = req_valid & req_ready;
    assign fp_csr   = (addr_p0 == 12'h001) || (addr_p0 == 12'h002) || (addr_p0 == 12'h003);
    assign fp_stall = fp_csr & fpu_pending[wid_p0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        req_ready        = 1'b0;
        rsp_valid        = 1'b0;
        csr_read_enable  = 1'b0;
        csr_write_enable = 1'b0;
        access           = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                // FP CSRs must not be touched while the FPU can still
                // update fflags for this warp.
                if (!fp_stall) begin
                    access           = 1'b1;
                    csr_read_enable  = 1'b1;
                    csr_write_enable = wr_req_p0;
                    state_next       = S_RSP;
                end
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // Nothing leaves the unit while reset is asserted; a half-done
        // access is simply abandoned.
        if (reset) begin
            state_next       = S_IDLE;
            req_ready        = 1'b0;
            rsp_valid        = 1'b0;
            csr_read_enable  = 1'b0;
            csr_write_enable = 1'b0;
            access           = 1'b0;
        end
    end

    // ---- request accept -> EXEC: latch request and resolve source operand
    always_ff @(posedge clk) begin
        if (req_fire) begin
            uuid_p0   <= req_uuid;
            wid_p0    <= req_wid;
            tmask_p0  <= req_tmask;
            op_p0     <= req_op;
            addr_p0   <= req_addr;
            rd_p0     <= req_rd;
            wb_p0     <= req_wb;
            src_p0    <= req_use_imm ? {27'd0, req_imm} : first_lane_data(req_tmask, req_rs1_data);
            // CSRRS/CSRRC with a zero rs1 index / uimm are pure reads.
            wr_req_p0 <= (req_op == OP_RW) || ((req_op != 2'b00) && (req_imm != 5'd0));
        end
    end

    // ---- EXEC -> RSP: capture the pre-write CSR value
    always_ff @(posedge clk) begin
        if (access) begin
            rsp_data_p1 <= {NUM_THREADS{csr_read_data}};
        end
    end

    assign csr_read_uuid  = uuid_p0;
    assign csr_read_addr  = addr_p0;
    assign csr_read_wid   = wid_p0;

    assign csr_write_uuid = uuid_p0;
    assign csr_write_addr = addr_p0;
    assign csr_write_wid  = wid_p0;
    assign csr_write_data = rmw_data(op_p0, csr_read_data, src_p0);

    assign csr_busy = !reset && ((state != S_IDLE) || req_valid);

    assign rsp_uuid  = uuid_p0;
    assign rsp_wid   = wid_p0;
    assign rsp_tmask = tmask_p0;
    assign rsp_data  = rsp_data_p1;
    assign rsp_rd    = rd_p0;
    assign rsp_wb    = wb_p0;

    // Op 00 has no encoding; it must never reach this unit.
    a_legal_op: assert property (@(posedge clk) disable iff (reset)
        (req_valid && req_ready) |-> (req_op != 2'b00));

endmodule

// File: tb/tb_csr_access_unit.sv
module tb_csr_access_unit;

    localparam int NT  = 4;
    localparam int NWP = 4;
    localparam int UB  = 44;
    localparam int NRB = 5;
    localparam int NWB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [UB-1:0]      req_uuid = '0;
    logic [NWB-1:0]     req_wid = '0;
    logic [NT-1:0]      req_tmask = 4'b0001;
    logic [1:0]         req_op = 2'b01;
    logic               req_use_imm = 1'b0;
    logic [4:0]         req_imm = '0;
    logic [11:0]        req_addr = '0;
    logic [NT*32-1:0]   req_rs1_data = '0;
    logic [NRB-1:0]     req_rd = '0;
    logic               req_wb = 1'b0;
    logic [NWP-1:0]     fpu_pending = '0;
    logic               csr_read_enable;
    logic [UB-1:0]      csr_read_uuid;
    logic [11:0]        csr_read_addr;
    logic [NWB-1:0]     csr_read_wid;
    logic [31:0]        csr_read_data;
    logic               csr_write_enable;
    logic [UB-1:0]      csr_write_uuid;
    logic [11:0]        csr_write_addr;
    logic [NWB-1:0]     csr_write_wid;
    logic [31:0]        csr_write_data;
    logic               csr_busy;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [UB-1:0]      rsp_uuid;
    logic [NWB-1:0]     rsp_wid;
    logic [NT-1:0]      rsp_tmask;
    logic [NT*32-1:0]   rsp_data;
    logic [NRB-1:0]     rsp_rd;
    logic               rsp_wb;

    csr_access_unit #(
        .NUM_THREADS(NT), .NUM_WARPS(NWP), .UUID_BITS(UB), .NR_BITS(NRB)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_uuid(req_uuid),
        .req_wid(req_wid), .req_tmask(req_tmask), .req_op(req_op),
        .req_use_imm(req_use_imm), .req_imm(req_imm), .req_addr(req_addr),
        .req_rs1_data(req_rs1_data), .req_rd(req_rd), .req_wb(req_wb),
        .fpu_pending(fpu_pending),
        .csr_read_enable(csr_read_enable), .csr_read_uuid(csr_read_uuid),
        .csr_read_addr(csr_read_addr), .csr_read_wid(csr_read_wid),
        .csr_read_data(csr_read_data),
        .csr_write_enable(csr_write_enable), .csr_write_uuid(csr_write_uuid),
        .csr_write_addr(csr_write_addr), .csr_write_wid(csr_write_wid),
        .csr_write_data(csr_write_data),
        .csr_busy(csr_busy),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uuid(rsp_uuid),
        .rsp_wid(rsp_wid), .rsp_tmask(rsp_tmask), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_wb(rsp_wb)
    );

    // CSR data block emulation: combinational read, write at the clock edge
    logic [31:0] env_mem [0:4095];
    logic        poke_en = 1'b0;
    logic [11:0] poke_addr = '0;
    logic [31:0] poke_data = '0;

    assign csr_read_data = env_mem[csr_read_addr];

    always @(posedge clk) begin
        if (poke_en) env_mem[poke_addr] <= poke_data;
        if (csr_write_enable) env_mem[csr_write_addr] <= csr_write_data;
    end

    // Reference CSR contents as the architecture says they should be
    logic [31:0] model_mem [0:4095];

    typedef struct {
        logic [31:0]    old_v;
        logic [31:0]    final_v;
        logic [11:0]    addr;
        logic           wr;
        logic [UB-1:0]  uuid;
        logic [NWB-1:0] wid;
        logic [NT-1:0]  tmask;
        logic [NRB-1:0] rd;
        logic           wb;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Environment driver for rsp_ready / fpu_pending (random or directed)
    logic           rand_en = 1'b0;
    logic           rsp_ready_dir = 1'b0;
    logic [NWP-1:0] pend_dir = '0;

    always @(posedge clk) begin
        #2;
        if (rand_en) begin
            rsp_ready = ($urandom_range(0, 9) < 7);
            for (int w = 0; w < NWP; w++) fpu_pending[w] = ($urandom_range(0, 9) < 3);
        end else begin
            rsp_ready   = rsp_ready_dir;
            fpu_pending = pend_dir;
        end
    end

    // Monitor / scoreboard
    int               wr_seen = 0;
    logic             prev_hold = 1'b0;
    logic [NT*32-1:0] prev_data;
    logic [UB-1:0]    prev_uuid;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("reset_rd_en", csr_read_enable, 0);
                chk("reset_wr_en", csr_write_enable, 0);
                chk("reset_rsp_valid", rsp_valid, 0);
                prev_hold = 1'b0;
            end else begin
                if (csr_write_enable) begin
                    wr_seen++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        chk("wr_addr", csr_write_addr, exp_q[0].addr);
                        chk("wr_uuid", csr_write_uuid, exp_q[0].uuid);
                        chk("wr_wid", csr_write_wid, exp_q[0].wid);
                        chk("wr_with_rd", csr_read_enable, 1);
                    end
                end
                if (csr_read_enable && (csr_read_addr inside {12'h001, 12'h002, 12'h003}))
                    chk("fp_stall_block", fpu_pending[csr_read_wid], 0);
                if (prev_hold) begin
                    chk("rsp_valid_held", rsp_valid, 1);
                    chk("rsp_data_stable", rsp_data, prev_data);
                    chk("rsp_uuid_stable", rsp_uuid, prev_uuid);
                end
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else if (rsp_ready) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("rsp_data", rsp_data, {NT{e.old_v}});
                        chk("rsp_uuid", rsp_uuid, e.uuid);
                        chk("rsp_wid", rsp_wid, e.wid);
                        chk("rsp_tmask", rsp_tmask, e.tmask);
                        chk("rsp_rd", rsp_rd, e.rd);
                        chk("rsp_wb", rsp_wb, e.wb);
                        chk("write_count", wr_seen, e.wr ? 1 : 0);
                        chk("csr_contents", env_mem[e.addr], e.final_v);
                        wr_seen = 0;
                    end
                end
                prev_hold = rsp_valid && !rsp_ready;
                prev_data = rsp_data;
                prev_uuid = rsp_uuid;
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
        poke_en = 1'b1; poke_addr = a; poke_data = v;
        model_mem[a] = v;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic use_imm, input logic [4:0] imm,
                         input logic [11:0] addr, input logic [1:0] wid, input logic [3:0] tmask,
                         input logic [127:0] rs1, input logic [4:0] rd, input logic wb);
        exp_t e;
        int n;
        int lane;
        logic [31:0] src;
        req_op = op; req_use_imm = use_imm; req_imm = imm; req_addr = addr;
        req_wid = wid; req_tmask = tmask; req_rs1_data = rs1; req_rd = rd; req_wb = wb;
        req_uuid = {12'($urandom_range(0, 4095)), 32'($urandom)};
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        // Architectural effect of the instruction
        lane = 0;
        while (!tmask[lane]) lane++;
        src = use_imm ? 32'(imm) : rs1[lane*32 +: 32];
        e.old_v = model_mem[addr];
        e.wr = (op == 2'b01) || (imm != 0);
        if (op == 2'b01) e.final_v = src;
        else if (op == 2'b10) e.final_v = e.old_v | src;
        else e.final_v = e.old_v & ~src;
        if (!e.wr) e.final_v = e.old_v;
        model_mem[addr] = e.final_v;
        e.addr = addr; e.uuid = req_uuid; e.wid = wid; e.tmask = tmask; e.rd = rd; e.wb = wb;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    logic [11:0] addr_list [7];
    logic [31:0] saved;

    initial begin
        addr_list[0] = 12'h001; addr_list[1] = 12'h002; addr_list[2] = 12'h003;
        addr_list[3] = 12'h300; addr_list[4] = 12'h305; addr_list[5] = 12'h341;
        addr_list[6] = 12'hC00;

        // Reset and initial CSR contents
        for (int i = 0; i < 7; i++) set_csr(addr_list[i], $urandom);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", csr_busy, 0);
        chk("rst_wr_en", csr_write_enable, 0);
        @(posedge clk); #1;

        // CSRRW x5 to 0x300, old value 0: write 0x1888 at T+1, rsp at T+2
        rsp_ready_dir = 1'b1;
        set_csr(12'h300, 32'h0);
        issue(2'b01, 1'b0, 5'd5, 12'h300, 2'd0, 4'b1111,
              {32'h3, 32'h2, 32'h1, 32'h0000_1888}, 5'd5, 1'b1);
        @(negedge clk);
        chk("lat_t1_rd_en", csr_read_enable, 1);
        chk("lat_t1_wr_en", csr_write_enable, 1);
        chk("lat_t1_wr_data", csr_write_data, 32'h1888);
        chk("lat_t1_rsp_valid", rsp_valid, 0);
        chk("lat_t1_busy", csr_busy, 1);
        @(negedge clk);
        chk("lat_t2_rsp_valid", rsp_valid, 1);
        drain();

        // CSRRS uimm=0 on 0xC00: read only
        set_csr(12'hC00, 32'h1234_5678);
        issue(2'b10, 1'b1, 5'd0, 12'hC00, 2'd3, 4'b0110, '0, 5'd7, 1'b1);
        drain();

        // CSRRC with tmask 1100: lane 2 supplies 0x0F, old 0xFF -> 0xF0
        set_csr(12'h341, 32'hFF);
        issue(2'b11, 1'b0, 5'd9, 12'h341, 2'd1, 4'b1100,
              {32'hAAAA_AAAA, 32'h0F, 32'hDEAD, 32'hBEEF}, 5'd3, 1'b1);
        drain();

        // FRM read held by FPU pending for 5 cycles
        pend_dir = 4'b0010;
        @(posedge clk); #1;
        issue(2'b10, 1'b1, 5'd0, 12'h002, 2'd1, 4'b0001, '0, 5'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("fp_hold_rd_en", csr_read_enable, 0);
            chk("fp_hold_wr_en", csr_write_enable, 0);
        end
        @(posedge clk); #1;
        pend_dir = '0;
        @(negedge clk);
        chk("fp_release_rd_en", csr_read_enable, 1);
        drain();

        // Response back-pressure: rsp held, next request waits for IDLE
        rsp_ready_dir = 1'b0;
        issue(2'b01, 1'b0, 5'd4, 12'h305, 2'd2, 4'b1010, {4{$urandom}}, 5'd9, 1'b0);
        req_op = 2'b10; req_use_imm = 1'b1; req_imm = 5'd3; req_addr = 12'h300;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("bp_req_ready", req_ready, 0);
                chk("bp_rsp_valid", rsp_valid, 1);
            end
        end
        @(posedge clk); #1;
        rsp_ready_dir = 1'b1;
        @(negedge clk);
        chk("bp_no_accept_on_rsp", req_ready, 0);
        issue(2'b10, 1'b1, 5'd3, 12'h300, 2'd2, 4'b0001, '0, 5'd2, 1'b1);
        drain();

        // Reset while FP-stalled in EXEC: no write, response dropped
        pend_dir = 4'b0100;
        @(posedge clk); #1;
        saved = model_mem[12'h003];
        issue(2'b01, 1'b0, 5'd6, 12'h003, 2'd2, 4'b0001, {4{32'h5A5A_5A5A}}, 5'd6, 1'b1);
        @(negedge clk);
        chk("rst_stall_wr_en", csr_write_enable, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", csr_busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        pend_dir = '0;
        void'(exp_q.pop_back());
        model_mem[12'h003] = saved;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        chk("post_rst_rd_en", csr_read_enable, 0);
        chk("post_rst_csr_kept", env_mem[12'h003], saved);
        @(negedge clk);
        chk("post_rst_rsp_valid2", rsp_valid, 0);
        @(posedge clk); #1;

        // Randomised traffic
        rand_en = 1'b1;
        for (int t = 0; t < 60; t++) begin
            logic [1:0] op;
            logic [4:0] imm;
            logic [3:0] tm;
            op = 2'($urandom_range(1, 3));
            imm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            tm = 4'($urandom_range(1, 15));
            issue(op, 1'($urandom), imm, addr_list[$urandom_range(0, 6)], 2'($urandom),
                  tm, {$urandom, $urandom, $urandom, $urandom}, 5'($urandom), 1'($urandom));
        end
        rand_en = 1'b0;
        rsp_ready_dir = 1'b1;
        pend_dir = '0;
        drain();

        for (int i = 0; i < 7; i++) chk("final_csr", env_mem[addr_list[i]], model_mem[addr_list[i]]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
